instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program-load memory, PC sequencing, IF/ID register.
// Optional halt-on-0xFFFFFFFF detection is enabled with FETCH_HALT_DETECT_EN.
//
// state  | meaning
// IDLE   | program may be loaded, PC held, IF/ID outputs NOP
// RUN    | fetching; redirect > stall > sequential fetch
// HALTED | halt word seen, PC held at halt address, outputs NOP
module instruction_fetch #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_clear,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [NB_DATA-1:0]     i_redirect_pc,
  input  logic                   i_load_we,
  input  logic [NB_MEM_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0]     i_load_data,
  output logic [NB_DATA-1:0]     o_instruction,
  output logic [NB_DATA-1:0]     o_pcounter4,
  output logic [NB_DATA-1:0]     o_pc,
  output logic                   o_halt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NB_DATA-1:0] mem [2**NB_MEM_ADDR];
  logic [NB_DATA-1:0] fetch_word;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] pc_next;
  logic [NB_DATA-1:0] instr_next;
  logic [NB_DATA-1:0] pc4_next;
  logic               halt_det;

  // Word-addressed: byte offset and bits above the memory range alias.
  assign fetch_word = mem[o_pc[NB_MEM_ADDR+1:2]];
  assign pc_plus4   = o_pc + NB_DATA'(4);

`ifdef FETCH_HALT_DETECT_EN
  assign halt_det = (fetch_word == {NB_DATA{1'b1}});
  assign o_halt   = (state == HALTED);
`else
  assign halt_det = 1'b0;
  assign o_halt   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = o_pc;
    instr_next = o_instruction;
    pc4_next   = o_pcounter4;
    case (state)
      IDLE: begin
        instr_next = '0;
        pc4_next   = '0;
        if (i_start) state_next = RUN;
      end
      RUN: begin
        if (i_redirect) begin
          pc_next    = i_redirect_pc;
          instr_next = '0;
          pc4_next   = '0;
        end else if (!i_stall) begin
          if (halt_det) begin
            state_next = HALTED;
            instr_next = '0;
            pc4_next   = '0;
          end else begin
            instr_next = fetch_word;
            pc4_next   = pc_plus4;
            pc_next    = pc_plus4;
          end
        end
      end
      HALTED: begin
        instr_next = '0;
        pc4_next   = '0;
        if (i_clear) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        instr_next = '0;
        pc4_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_pc          <= '0;
      o_instruction <= '0;
      o_pcounter4   <= '0;
    end else begin
      state         <= state_next;
      o_pc          <= pc_next;
      o_instruction <= instr_next;
      o_pcounter4   <= pc4_next;
    end
  end

  // Memory survives reset; a load coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (i_rst_n && (state == IDLE) && i_load_we) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a per-cycle reference model pushes
// expected IF outputs; a monitor pops and compares after every clock edge.
module tb_instruction_fetch;

  localparam int NB_DATA     = 32;
  localparam int NB_MEM_ADDR = 8;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, clear, stall, redirect, load_we;
  logic [31:0] redirect_pc, load_data;
  logic [7:0]  load_addr;
  logic [31:0] instruction, pcounter4, pc;
  logic        halt;

  instruction_fetch #(.NB_DATA(NB_DATA), .NB_MEM_ADDR(NB_MEM_ADDR)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_clear      (clear),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_load_we    (load_we),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .o_instruction(instruction),
    .o_pcounter4  (pcounter4),
    .o_pc         (pc),
    .o_halt       (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] p4;
    logic [31:0] pc;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;

  // stimulus for the next tick; reset to defaults after each tick
  bit          s_rst_n = 1, s_start = 0, s_clear = 0, s_stall = 0, s_redir = 0, s_we = 0;
  logic [31:0] s_rpc = 0, s_ld = 0;
  logic [7:0]  s_la = 0;

  // reference model: behavioural view of the fetch unit
  logic [31:0] m_mem [256];
  int          m_mode = 0;        // 0 idle, 1 running, 2 halted
  logic [31:0] m_pc = 0, m_ins = 0, m_p4 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (!s_rst_n) begin
      m_mode = 0; m_pc = 0; m_ins = 0; m_p4 = 0;
      return;
    end
    if (m_mode == 0) begin
      if (s_we) m_mem[s_la] = s_ld;
      if (s_start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (s_redir) begin
        m_pc = s_rpc; m_ins = 0; m_p4 = 0;
      end else if (!s_stall) begin
        w = m_mem[m_pc[9:2]];
        if (HALT_EN && w == 32'hFFFF_FFFF) begin
          m_mode = 2; m_ins = 0; m_p4 = 0;
        end else begin
          m_ins = w;
          m_p4  = m_pc + 32'd4;
          m_pc  = m_pc + 32'd4;
        end
      end
    end else begin
      if (s_clear) m_mode = 0;
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    rst_n = s_rst_n; start = s_start; clear = s_clear; stall = s_stall;
    redirect = s_redir; redirect_pc = s_rpc; load_we = s_we;
    load_addr = s_la; load_data = s_ld;
    model_step();
    e.ins = m_ins; e.p4 = m_p4; e.pc = m_pc; e.halt = (m_mode == 2);
    exp_q.push_back(e);
    pushed++;
    s_rst_n = 1; s_start = 0; s_clear = 0; s_stall = 0; s_redir = 0; s_we = 0;
    s_rpc = 0; s_la = 0; s_ld = 0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    s_we = 1; s_la = 8'(a); s_ld = d;
    tick();
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        check("sb_instruction", instruction, e.ins);
        check("sb_pcounter4", pcounter4, e.p4);
        check("sb_pc", pc, e.pc);
        check("sb_halt", {31'd0, halt}, {31'd0, e.halt});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    rst_n = 0; start = 0; clear = 0; stall = 0; redirect = 0;
    redirect_pc = 0; load_we = 0; load_addr = 0; load_data = 0;

    s_rst_n = 0; tick();
    s_rst_n = 0; tick();
    after_edge();
    check("reset_pc", pc, 32'h0);
    check("reset_instruction", instruction, 32'h0);
    check("reset_halt", {31'd0, halt}, 32'h0);

    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      if (d == 32'hFFFF_FFFF) d = 32'h0;
      load(i, d);
    end
    load(0, 32'h2001_0005);
    load(1, 32'h2002_0007);
    load(2, 32'h0022_1820);
    load(3, 32'hFFFF_FFFF);
    load(16, 32'h1234_5678);
    load(255, 32'h0BAD_F00D);

    // three-instruction program
    s_start = 1; tick();
    tick(); after_edge();
    check("prog_ins0", instruction, 32'h2001_0005);
    check("prog_pc4_0", pcounter4, 32'd4);
    tick(); after_edge();
    check("prog_ins1", instruction, 32'h2002_0007);
    check("prog_pc4_1", pcounter4, 32'd8);
    tick(); after_edge();
    check("prog_ins2", instruction, 32'h0022_1820);
    check("prog_pc4_2", pcounter4, 32'd12);
    tick(); after_edge();
`ifdef FETCH_HALT_DETECT_EN
    check("halt_flag", {31'd0, halt}, 32'd1);
    check("halt_pc", pc, 32'd12);
    check("halt_ins", instruction, 32'h0);
    tick(); after_edge();
    check("halted_hold_pc", pc, 32'd12);
    s_clear = 1; tick(); after_edge();
    check("clear_halt", {31'd0, halt}, 32'd0);
`else
    check("nohalt_ins", instruction, 32'hFFFF_FFFF);
    check("nohalt_flag", {31'd0, halt}, 32'd0);
`endif

    // stall at pc 8
    s_rst_n = 0; tick();
    s_start = 1; tick();
    tick(); tick(); after_edge();
    check("pre_stall_pc", pc, 32'd8);
    for (int i = 0; i < 3; i++) begin
      s_stall = 1; tick(); after_edge();
      check("stall_pc", pc, 32'd8);
      check("stall_ins", instruction, 32'h2002_0007);
      check("stall_pc4", pcounter4, 32'd8);
    end
    tick(); after_edge();
    check("resume_ins", instruction, 32'h0022_1820);
    check("resume_pc4", pcounter4, 32'd12);

    // redirect beats stall
    s_redir = 1; s_stall = 1; s_rpc = 32'h40; tick(); after_edge();
    check("redir_pc", pc, 32'h40);
    check("redir_flush", instruction, 32'h0);
    tick(); after_edge();
    check("redir_ins", instruction, 32'h1234_5678);
    check("redir_pc4", pcounter4, 32'h44);

    // PC wrap
    s_redir = 1; s_rpc = 32'hFFFF_FFFC; tick();
    tick(); after_edge();
    check("wrap_ins", instruction, 32'h0BAD_F00D);
    check("wrap_pc4", pcounter4, 32'h0);
    check("wrap_pc", pc, 32'h0);

    // load ignored in RUN, reset mid-run keeps memory
    load(0, 32'hDEAD_BEEF);
    s_redir = 1; s_rpc = 32'h10; tick();
    s_rst_n = 0; tick(); after_edge();
    check("midrun_reset_pc", pc, 32'h0);
    check("midrun_reset_ins", instruction, 32'h0);
    check("midrun_reset_pc4", pcounter4, 32'h0);
    s_start = 1; tick();
    tick(); after_edge();
    check("mem_kept_ins0", instruction, 32'h2001_0005);

    // load coincident with reset is dropped
    s_rst_n = 0; s_we = 1; s_la = 8'd1; s_ld = 32'hCAFE_0001; tick();
    load(2, 32'h0022_1820);
    s_start = 1; tick();
    tick(); tick(); after_edge();
    check("rst_load_drop", instruction, 32'h2002_0007);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s_rst_n = ($urandom_range(0, 99) != 0);
      s_start = ($urandom_range(0, 3) == 0);
      s_clear = ($urandom_range(0, 3) == 0);
      s_stall = ($urandom_range(0, 4) == 0);
      s_redir = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: s_rpc = $urandom;
        1: s_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: s_rpc = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
      endcase
      s_we = ($urandom_range(0, 2) == 0);
      s_la = 8'($urandom_range(0, 255));
      s_ld = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
      tick();
    end

    tick();
    after_edge();
    after_edge();
    check("scoreboard_drain", 32'(popped), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
